// File: rtl/crank_wheel_decoder.sv
// crank_wheel_decoder: conditions the raw crank/VR input and decodes an
// N-M missing-tooth wheel into sync, tooth index, strobe and tooth period.
`timescale 1ns/1ps

module crank_wheel_decoder #(
  parameter int TEETH_TOTAL   = 36,
  parameter int TEETH_MISSING = 1,
  parameter int FILT_CYCLES   = 4,
  parameter int PERIOD_W      = 20,
  parameter int IDX_W         = 6
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                vrin,
  output logic                synced,
  output logic                tooth_strobe,
  output logic [IDX_W-1:0]    tooth_idx,
  output logic [PERIOD_W-1:0] tooth_period,
  output logic                sync_loss
);

  // Index of the tooth just before the gap; the gap is expected after it.
  localparam int                  LAST     = TEETH_TOTAL - TEETH_MISSING - 1;
  localparam logic [IDX_W-1:0]    LAST_IDX = IDX_W'(LAST);
  localparam logic [PERIOD_W-1:0] CNT_MAX  = '1;
  localparam int                  FC_W     = $clog2(FILT_CYCLES + 1);
  localparam logic [FC_W-1:0]     FC_LAST  = FC_W'(FILT_CYCLES - 1);

  localparam logic [1:0] ST_UNSYNC = 2'd0;
  localparam logic [1:0] ST_ARMED  = 2'd1;
  localparam logic [1:0] ST_SYNCED = 2'd2;

  // A tooth interval is a gap when it exceeds 1.5x the previous one.
  // Both sides are widened by two bits so 3*prev can never wrap.
  function automatic logic is_gap(input logic [PERIOD_W-1:0] m,
                                  input logic [PERIOD_W-1:0] p);
    logic [PERIOD_W+1:0] two_m;
    logic [PERIOD_W+1:0] three_p;
    two_m   = {1'b0, m, 1'b0};
    three_p = {2'b00, p} + {1'b0, p, 1'b0};
    return two_m > three_p;
  endfunction

  // Counter increment that parks at all-ones, which marks a stalled wheel.
  function automatic logic [PERIOD_W-1:0] sat_inc(input logic [PERIOD_W-1:0] c);
    return (c == CNT_MAX) ? c : c + PERIOD_W'(1);
  endfunction

  logic            sync_p0;
  logic            sync_p1;
  logic            filt;
  logic [FC_W-1:0] fcnt;
  logic            rise_p0;
  logic            rise_p1;

  logic [PERIOD_W-1:0] cnt;
  logic [PERIOD_W-1:0] meas;
  logic [PERIOD_W-1:0] prev;
  logic [1:0]          state;
  logic                stall;
  logic                gap;

  // Stage p0/p1: two-flop synchronizer, glitch filter and registered rising-edge pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      filt    <= 1'b0;
      fcnt    <= '0;
      rise_p0 <= 1'b0;
      rise_p1 <= 1'b0;
    end else begin
      sync_p0 <= vrin;
      sync_p1 <= sync_p0;
      rise_p0 <= 1'b0;
      rise_p1 <= rise_p0;
      if (sync_p1 != filt) begin
        if (fcnt == FC_LAST) begin
          filt    <= sync_p1;
          fcnt    <= '0;
          rise_p0 <= sync_p1;
        end else begin
          fcnt <= fcnt + FC_W'(1);
        end
      end else begin
        fcnt <= '0;
      end
    end
  end

  assign meas  = cnt;
  assign stall = (cnt == CNT_MAX);
  assign gap   = is_gap(meas, prev);

  // Period counter: restarts at 1 on each accepted edge so edges N clocks apart measure N.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (rise_p1) begin
      cnt <= PERIOD_W'(1);
    end else begin
      cnt <= sat_inc(cnt);
    end
  end

  // Previous tooth interval; a saturated (stalled) measurement is never kept.
  always_ff @(posedge clk) begin
    if (rise_p1 && !stall) begin
      prev <= meas;
    end
  end

  // Stage p2: sync state machine and decoder outputs; a stall overrides any edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_UNSYNC;
      synced       <= 1'b0;
      tooth_strobe <= 1'b0;
      sync_loss    <= 1'b0;
      tooth_idx    <= '0;
      tooth_period <= '0;
    end else begin
      tooth_strobe <= 1'b0;
      sync_loss    <= 1'b0;
      if (stall) begin
        state  <= ST_UNSYNC;
        synced <= 1'b0;
        if (state == ST_SYNCED) begin
          sync_loss <= 1'b1;
        end
      end else if (rise_p1) begin
        case (state)
          ST_UNSYNC: begin
            state <= ST_ARMED;
          end
          ST_ARMED: begin
            if (gap) begin
              state        <= ST_SYNCED;
              synced       <= 1'b1;
              tooth_idx    <= '0;
              tooth_strobe <= 1'b1;
              tooth_period <= meas;
            end
          end
          ST_SYNCED: begin
            tooth_period <= meas;
            if ((tooth_idx == LAST_IDX) && gap) begin
              tooth_idx    <= '0;
              tooth_strobe <= 1'b1;
            end else if ((tooth_idx != LAST_IDX) && !gap) begin
              tooth_idx    <= tooth_idx + IDX_W'(1);
              tooth_strobe <= 1'b1;
            end else begin
              state     <= ST_ARMED;
              synced    <= 1'b0;
              sync_loss <= 1'b1;
            end
          end
          default: begin
            state  <= ST_UNSYNC;
            synced <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_crank_wheel_decoder.sv
// Directed bench for crank_wheel_decoder on a 36-1 wheel with a short
// period counter so that a stall is reachable in a few thousand clocks.
`timescale 1ns/1ps

module tb_crank_wheel_decoder;

  localparam int PW = 12;
  localparam int IW = 6;

  logic          clk;
  logic          reset;
  logic          vrin;
  logic          synced;
  logic          tooth_strobe;
  logic [IW-1:0] tooth_idx;
  logic [PW-1:0] tooth_period;
  logic          sync_loss;

  crank_wheel_decoder #(
    .TEETH_TOTAL(36), .TEETH_MISSING(1), .FILT_CYCLES(4), .PERIOD_W(PW), .IDX_W(IW)
  ) dut (
    .clk(clk), .reset(reset), .vrin(vrin), .synced(synced),
    .tooth_strobe(tooth_strobe), .tooth_idx(tooth_idx),
    .tooth_period(tooth_period), .sync_loss(sync_loss)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One record per tooth: tooth length in clocks, glitch injection, and the
  // outputs expected once that tooth's rising edge has been decoded.
  typedef struct {
    int p;
    bit glitch;
    bit dc;
    bit exp_synced;
    int exp_idx;
    int exp_period;
    int exp_strobes;
    int exp_losses;
  } vec_t;

  vec_t vecs[$];
  int checks = 0;
  int errors = 0;
  int strobe_tot = 0;
  int loss_tot = 0;
  int both_tot = 0;

  // Pulse counters sampled on the falling edge.
  always @(negedge clk) begin
    if (tooth_strobe) strobe_tot <= strobe_tot + 1;
    if (sync_loss) loss_tot <= loss_tot + 1;
    if (tooth_strobe && sync_loss) both_tot <= both_tot + 1;
  end

  function automatic void add(int p, bit g, bit dc, bit s, int idx, int per, int st, int ls);
    vec_t v;
    v.p = p; v.glitch = g; v.dc = dc; v.exp_synced = s; v.exp_idx = idx;
    v.exp_period = per; v.exp_strobes = st; v.exp_losses = ls;
    vecs.push_back(v);
  endfunction

  task automatic tick(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual %0d required %0d", name, act, exp);
    end
  endtask

  // Rising edge at the start, 100 clocks high, then low for the rest.
  // The glitch variant adds a 3-clock dropout in the high phase and a
  // 3-clock spike in the low phase.
  task automatic tooth(int p, bit g);
    if (!g) begin
      vrin = 1'b1; tick(100);
      vrin = 1'b0; tick(p - 100);
    end else begin
      vrin = 1'b1; tick(40);
      vrin = 1'b0; tick(3);
      vrin = 1'b1; tick(57);
      vrin = 1'b0; tick(50);
      vrin = 1'b1; tick(3);
      vrin = 1'b0; tick(p - 153);
    end
  endtask

  task automatic run_vecs(int lo, int hi);
    for (int i = lo; i < hi; i++) begin
      vec_t v;
      int s0;
      int l0;
      v = vecs[i];
      s0 = strobe_tot;
      l0 = loss_tot;
      tooth(v.p, v.glitch);
      chk($sformatf("v%0d_synced", i), int'(synced), int'(v.exp_synced));
      if (!v.dc) begin
        chk($sformatf("v%0d_idx", i), int'(tooth_idx), v.exp_idx);
        chk($sformatf("v%0d_period", i), int'(tooth_period), v.exp_period);
      end
      chk($sformatf("v%0d_strobes", i), strobe_tot - s0, v.exp_strobes);
      chk($sformatf("v%0d_losses", i), loss_tot - l0, v.exp_losses);
    end
  endtask

  initial begin
    int seg_a;
    int seg_b;
    int seg_c;
    int seg_d;
    int seg_e;
    int cur;
    int last;
    int p;
    int k;
    int n;
    int s0;
    int l0;

    // Acquisition: 34 normal teeth, the gap tooth, then three synced revolutions.
    for (int i = 0; i < 34; i++) add(200, 0, 0, 0, 0, 0, 0, 0);
    add(400, 0, 0, 0, 0, 0, 0, 0);
    for (int r = 0; r < 3; r++)
      for (int j = 0; j < 35; j++)
        add((j == 34) ? 400 : 200, (r == 2) && (j == 5 || j == 20), 0, 1, j,
            (j == 0) ? 400 : 200, 1, 0);
    seg_a = vecs.size();

    // Tooth 10 stretched to 400: loss on the next edge, relock at the real gap.
    for (int j = 0; j <= 10; j++)
      add((j == 10) ? 400 : 200, 0, 0, 1, j, (j == 0) ? 400 : 200, 1, 0);
    add(200, 0, 0, 0, 10, 400, 0, 1);
    for (int j = 12; j < 34; j++) add(200, 0, 0, 0, 10, 400, 0, 0);
    add(400, 0, 0, 0, 10, 400, 0, 0);
    add(200, 0, 0, 1, 0, 400, 1, 0);
    seg_b = vecs.size();

    // Restart after a stall: one full revolution before relock.
    for (int j = 0; j < 35; j++) add((j == 34) ? 400 : 200, 0, 1, 0, 0, 0, 0, 0);
    add(200, 0, 0, 1, 0, 400, 1, 0);
    seg_c = vecs.size();

    // Run on to tooth 20 (tooth 1 is handled by the latency check).
    for (int j = 2; j <= 20; j++) add(200, 0, 0, 1, j, 200, 1, 0);
    seg_d = vecs.size();

    // After a mid-run reset: reacquire, then ramp 200 -> 150 at about 1% per tooth.
    for (int i = 0; i < 34; i++) add(200, 0, 0, 0, 0, 0, 0, 0);
    add(400, 0, 0, 0, 0, 0, 0, 0);
    add(200, 0, 0, 1, 0, 400, 1, 0);
    cur = 200;
    last = 200;
    for (int m = 0; m < 46; m++) begin
      k = (m + 1) % 35;
      if (k == 34) begin
        p = 2 * cur;
      end else begin
        cur = cur * 99 / 100;
        if (cur < 150) cur = 150;
        p = cur;
      end
      add(p, 0, 0, 1, k, last, 1, 0);
      last = p;
    end
    seg_e = vecs.size();

    reset = 1'b1;
    vrin = 1'b0;
    tick(5);
    chk("reset_synced", int'(synced), 0);
    chk("reset_strobe", int'(tooth_strobe), 0);
    chk("reset_idx", int'(tooth_idx), 0);
    chk("reset_period", int'(tooth_period), 0);
    chk("reset_loss", int'(sync_loss), 0);
    reset = 1'b0;
    tick(200);

    run_vecs(0, seg_a);
    run_vecs(seg_a, seg_b);

    // Hold the input low while synced until the period counter saturates.
    s0 = strobe_tot;
    l0 = loss_tot;
    tick(3000);
    chk("stall_pre_synced", int'(synced), 1);
    chk("stall_pre_losses", loss_tot - l0, 0);
    tick(2000);
    chk("stall_synced", int'(synced), 0);
    chk("stall_losses", loss_tot - l0, 1);
    chk("stall_strobes", strobe_tot - s0, 0);

    run_vecs(seg_b, seg_c);

    // Edge-to-strobe latency: first clock sampling vrin high to strobe is 7 clocks.
    vrin = 1'b1;
    n = 0;
    for (int c = 1; c <= 20; c++) begin
      tick(1);
      if (tooth_strobe) begin
        n = c;
        break;
      end
    end
    if (n == 0) n = 21;
    chk("latency_clocks", n - 1, 7);
    tick(100 - n);
    vrin = 1'b0;
    tick(100);
    chk("latency_idx", int'(tooth_idx), 1);

    run_vecs(seg_c, seg_d);

    // Reset in the middle of a synced run.
    reset = 1'b1;
    tick(1);
    chk("midreset_synced", int'(synced), 0);
    chk("midreset_strobe", int'(tooth_strobe), 0);
    chk("midreset_idx", int'(tooth_idx), 0);
    chk("midreset_period", int'(tooth_period), 0);
    chk("midreset_loss", int'(sync_loss), 0);
    tick(4);
    reset = 1'b0;
    tick(300);

    run_vecs(seg_d, seg_e);

    tick(2);
    chk("strobe_loss_overlap", both_tot, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
